// File: rtl/dcache_store_handler_pkg.sv
// Shared widths, types and helpers for the DCache store-commit write handler.
package dcache_store_handler_pkg;

    localparam int unsigned PADDR_SIZE = 32;
    localparam int unsigned BANK       = 4;
    localparam int unsigned BITS       = 32;
    localparam int unsigned BYTE       = 4;
    localparam int unsigned SC_W       = 3;
    localparam int unsigned WAY_NUM    = 4;
    localparam int unsigned SET_W      = 6;
    localparam int unsigned LINE_W     = 4;
    localparam int unsigned MISS_SIZE  = 2;

    localparam int unsigned WAY_W   = $clog2(WAY_NUM);
    localparam int unsigned MISS_W  = $clog2(MISS_SIZE);
    localparam int unsigned DATA_W  = BANK * BITS;
    localparam int unsigned MASK_W  = BANK * BYTE;
    localparam int unsigned LADDR_W = PADDR_SIZE - LINE_W;

    typedef logic [LADDR_W-1:0] line_t;
    typedef logic [SET_W-1:0]   set_t;
    typedef logic [WAY_W-1:0]   way_t;
    typedef logic [SC_W-1:0]    sc_t;
    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [MASK_W-1:0]  mask_t;

    typedef struct packed {
        logic  v;
        logic  issued;
        line_t line;
        sc_t   scIdx;
        data_t data;
        mask_t mask;
    } StoreMissEntry;

    function automatic set_t set_of(input line_t line);
        return line[SET_W-1:0];
    endfunction

endpackage

// File: rtl/dcache_store_handler_store_miss_table.sv
// Store-miss table: parks missed line writes, issues the oldest to the miss unit,
// and hands back the matching entry for a merge write once its refill completes.
module store_miss_table
    import dcache_store_handler_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_en,
    input  line_t                 alloc_line,
    input  sc_t                   alloc_idx,
    input  data_t                 alloc_data,
    input  mask_t                 alloc_mask,
    input  line_t                 lookup_line,
    output logic                  lookup_hit,
    output logic                  full,
    output logic                  miss_req,
    output logic [PADDR_SIZE-1:0] miss_addr,
    input  logic                  miss_ready,
    input  logic                  refill_done,
    input  line_t                 refill_line,
    input  way_t                  refill_way,
    output logic                  merge_valid,
    output set_t                  merge_set,
    output way_t                  merge_way,
    output sc_t                   merge_idx,
    output data_t                 merge_data,
    output mask_t                 merge_mask
);

    StoreMissEntry        tbl   [MISS_SIZE];
    logic [MISS_SIZE-1:0] older [MISS_SIZE];   // older[i][j]: entry i allocated before entry j
    logic [MISS_SIZE-1:0] pending;
    logic [MISS_W-1:0]    alloc_ptr, issue_ptr, match_ptr, merge_ptr;
    logic                 alloc_found, match_hit, is_oldest;

    always_comb begin
        lookup_hit  = 1'b0;
        full        = 1'b1;
        alloc_found = 1'b0;
        alloc_ptr   = '0;
        miss_req    = 1'b0;
        issue_ptr   = '0;
        is_oldest   = 1'b0;
        match_hit   = 1'b0;
        match_ptr   = '0;
        for (int unsigned i = 0; i < MISS_SIZE; i++) begin
            pending[i] = tbl[i].v & ~tbl[i].issued;
            if (tbl[i].v && tbl[i].line == lookup_line)
                lookup_hit = 1'b1;
            if (!tbl[i].v) begin
                full = 1'b0;
                if (!alloc_found) begin
                    alloc_found = 1'b1;
                    alloc_ptr   = MISS_W'(i);
                end
            end
        end
        for (int unsigned i = 0; i < MISS_SIZE; i++) begin
            is_oldest = pending[i];
            for (int unsigned j = 0; j < MISS_SIZE; j++)
                if (j != i && pending[j] && !older[i][j])
                    is_oldest = 1'b0;
            if (is_oldest) begin
                miss_req  = 1'b1;
                issue_ptr = MISS_W'(i);
            end
        end
        // An entry already being merged this cycle must not be matched a second time.
        for (int unsigned i = 0; i < MISS_SIZE; i++) begin
            if (!match_hit && tbl[i].v && tbl[i].issued && tbl[i].line == refill_line
                && !(merge_valid && merge_ptr == MISS_W'(i))) begin
                match_hit = 1'b1;
                match_ptr = MISS_W'(i);
            end
        end
    end

    assign miss_addr  = {tbl[issue_ptr].line, {LINE_W{1'b0}}};
    assign merge_set  = set_of(tbl[merge_ptr].line);
    assign merge_idx  = tbl[merge_ptr].scIdx;
    assign merge_data = tbl[merge_ptr].data;
    assign merge_mask = tbl[merge_ptr].mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MISS_SIZE; i++) begin
                tbl[i]   <= '0;
                older[i] <= '0;
            end
            merge_valid <= 1'b0;
            merge_ptr   <= '0;
            merge_way   <= '0;
        end else begin
            merge_valid <= refill_done & match_hit;
            merge_ptr   <= match_ptr;
            merge_way   <= refill_way;
            if (miss_req && miss_ready)
                tbl[issue_ptr].issued <= 1'b1;
            if (merge_valid)
                tbl[merge_ptr].v <= 1'b0;
            if (alloc_en) begin
                tbl[alloc_ptr] <= '{v: 1'b1, issued: 1'b0, line: alloc_line, scIdx: alloc_idx,
                                    data: alloc_data, mask: alloc_mask};
                for (int unsigned j = 0; j < MISS_SIZE; j++) begin
                    older[alloc_ptr][j] <= 1'b0;
                    older[j][alloc_ptr] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dcache_store_handler.sv
// DCache store handler: 3-stage lookup pipe for commit-buffer line writes,
// hit writes / miss parking, and data-port arbitration against refill merges.
module dcache_store_handler
    import dcache_store_handler_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [SC_W-1:0]       scIdx,
    input  logic [PADDR_SIZE-1:0] paddr,
    input  logic [DATA_W-1:0]     data,
    input  logic [MASK_W-1:0]     mask,
    output logic                  valid,
    output logic                  conflict,
    output logic                  success,
    output logic [SC_W-1:0]       conflictIdx,
    output logic                  refill,
    output logic [SC_W-1:0]       refillIdx,
    output logic                  tag_req,
    output logic [SET_W-1:0]      tag_set,
    input  logic                  tag_hit,
    input  logic [WAY_W-1:0]      tag_way,
    output logic                  dwr_en,
    output logic [SET_W-1:0]      dwr_set,
    output logic [WAY_W-1:0]      dwr_way,
    output logic [DATA_W-1:0]     dwr_data,
    output logic [MASK_W-1:0]     dwr_mask,
    output logic                  miss_req,
    output logic [PADDR_SIZE-1:0] miss_addr,
    input  logic                  miss_ready,
    input  logic                  refill_done,
    input  logic [LADDR_W-1:0]    refill_line,
    input  logic [WAY_W-1:0]      refill_way,
    input  logic                  refill_busy
);

    logic  accept, unused_paddr_lo;
    logic  s1_v, s2_v, s2_hit;
    line_t s1_line, s2_line;
    sc_t   s1_idx, s2_idx;
    data_t s1_data, s2_data;
    mask_t s1_mask, s2_mask;
    way_t  s2_way;

    logic  lookup_hit, full, alloc_en, merge_valid;
    set_t  merge_set;
    way_t  merge_way;
    sc_t   merge_idx;
    data_t merge_data;
    mask_t merge_mask;

    assign valid           = ~rst & ~refill_busy & ~merge_valid;
    assign accept          = req & valid;
    assign tag_req         = accept;
    assign tag_set         = paddr[LINE_W +: SET_W];
    assign unused_paddr_lo = ^paddr[LINE_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_line <= '0;
            s1_idx  <= '0;
            s1_data <= '0;
            s1_mask <= '0;
            s2_v    <= 1'b0;
            s2_hit  <= 1'b0;
            s2_way  <= '0;
            s2_line <= '0;
            s2_idx  <= '0;
            s2_data <= '0;
            s2_mask <= '0;
        end else begin
            s1_v    <= accept;
            s1_line <= paddr[PADDR_SIZE-1:LINE_W];
            s1_idx  <= scIdx;
            s1_data <= data;
            s1_mask <= mask;
            s2_v    <= s1_v;
            s2_hit  <= tag_hit;
            s2_way  <= tag_way;
            s2_line <= s1_line;
            s2_idx  <= s1_idx;
            s2_data <= s1_data;
            s2_mask <= s1_mask;
        end
    end

    // Refill merge owns the data port; a coinciding hit is bounced back for retry.
    always_comb begin
        dwr_en      = 1'b0;
        dwr_set     = '0;
        dwr_way     = '0;
        dwr_data    = '0;
        dwr_mask    = '0;
        success     = 1'b0;
        conflict    = 1'b0;
        conflictIdx = '0;
        refill      = 1'b0;
        refillIdx   = '0;
        alloc_en    = 1'b0;
        if (merge_valid) begin
            dwr_en    = 1'b1;
            dwr_set   = merge_set;
            dwr_way   = merge_way;
            dwr_data  = merge_data;
            dwr_mask  = merge_mask;
            refill    = 1'b1;
            refillIdx = merge_idx;
        end
        if (s2_v) begin
            conflictIdx = s2_idx;
            if (s2_hit) begin
                if (merge_valid) begin
                    conflict = 1'b1;
                end else begin
                    dwr_en   = 1'b1;
                    dwr_set  = set_of(s2_line);
                    dwr_way  = s2_way;
                    dwr_data = s2_data;
                    dwr_mask = s2_mask;
                    success  = 1'b1;
                end
            end else if (lookup_hit || full) begin
                conflict = 1'b1;
            end else begin
                alloc_en = 1'b1;
            end
        end
    end

    store_miss_table u_smt (
        .clk         (clk),
        .rst         (rst),
        .alloc_en    (alloc_en),
        .alloc_line  (s2_line),
        .alloc_idx   (s2_idx),
        .alloc_data  (s2_data),
        .alloc_mask  (s2_mask),
        .lookup_line (s2_line),
        .lookup_hit  (lookup_hit),
        .full        (full),
        .miss_req    (miss_req),
        .miss_addr   (miss_addr),
        .miss_ready  (miss_ready),
        .refill_done (refill_done),
        .refill_line (refill_line),
        .refill_way  (refill_way),
        .merge_valid (merge_valid),
        .merge_set   (merge_set),
        .merge_way   (merge_way),
        .merge_idx   (merge_idx),
        .merge_data  (merge_data),
        .merge_mask  (merge_mask)
    );

endmodule
